// File: rtl/mem_access_sequencer_pkg.sv
// Shared encodings for the memory access sequencer: access sizes, FSM
// states, and the RAM_OpCode field layout.
package mem_access_sequencer_pkg;

  localparam logic [1:0] SZ_BYTE   = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b01;
  localparam logic [1:0] SZ_WORD   = 2'b10;
  localparam logic [1:0] SZ_DOUBLE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_LATCH,
    ST_NEXT,
    ST_DONE
  } state_t;

  // RAM_OpCode = {2'b00, rw, signed, size}. A doubleword goes to RAM as two
  // word accesses, so its size field is reported as a word.
  function automatic logic [5:0] ram_opcode(input logic rw, input logic sgn,
                                            input logic [1:0] size);
    logic [1:0] sz;
    sz = (size == SZ_DOUBLE) ? SZ_WORD : size;
    return {2'b00, rw, sgn, sz};
  endfunction

  // Natural alignment check on the low address bits.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] a);
    case (size)
      SZ_HALF:   return a[0];
      SZ_WORD:   return |a[1:0];
      SZ_DOUBLE: return |a;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_sequencer_load_data_aligner.sv
// Combinational load data extraction: byte/half taken from the low lanes of
// the RAM word and sign- or zero-extended; word/double passed through.
module load_data_aligner
  import mem_access_sequencer_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] data
);

  // Select lane width and fill the upper bits from the sign bit if requested.
  always_comb begin
    case (size)
      SZ_BYTE: data = {{24{sgn & raw[7]}}, raw[7:0]};
      SZ_HALF: data = {{16{sgn & raw[15]}}, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Multi-cycle load/store sequencer between the control unit and the RAM
// port. One request at a time; doublewords are split into two word phases.
module mem_access_sequencer
  import mem_access_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int SETUP_CYCLES   = 1
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic        MFC,
  input  logic [31:0] ram_rdata,
  output logic [31:0] mar_out,
  output logic [31:0] mdr_out,
  output logic        RAM_enable,
  output logic [5:0]  RAM_OpCode,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_misaligned,
  output logic        rsp_timeout
);

  localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES + 1) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_n;
  logic          rw_q, sgn_q, phase_q;
  logic [1:0]    size_q;
  logic [31:0]   wlo_q;
  logic [SW-1:0] setup_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [63:0]   rdata_q;
  logic          mis_q, tmo_q;
  logic [31:0]   aligned;

  load_data_aligner u_align (
    .raw  (ram_rdata),
    .size (size_q),
    .sgn  (sgn_q),
    .data (aligned)
  );

  assign req_ready      = (state == ST_IDLE);
  assign RAM_enable     = (state == ST_ACCESS);
  assign rsp_valid      = (state == ST_DONE);
  assign RAM_OpCode     = ram_opcode(rw_q, sgn_q, size_q);
  assign rsp_rdata      = rdata_q;
  assign rsp_misaligned = mis_q;
  assign rsp_timeout    = tmo_q;

  // State register.
  always_ff @(posedge Clk) begin
    if (!Clr) state <= ST_IDLE;
    else      state <= state_n;
  end

  // Next-state: misaligned requests skip the RAM entirely; MFC beats timeout.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (req_valid)
                   state_n = is_misaligned(req_size, req_addr[2:0]) ? ST_DONE : ST_SETUP;
      ST_SETUP:  if (setup_cnt == SETUP_LAST) state_n = ST_ACCESS;
      ST_ACCESS: if (MFC)                      state_n = ST_LATCH;
                 else if (tmo_cnt == TMO_LAST) state_n = ST_DONE;
      ST_LATCH:  state_n = (size_q == SZ_DOUBLE && !phase_q) ? ST_NEXT : ST_DONE;
      ST_NEXT:   state_n = ST_SETUP;
      ST_DONE:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Request latches, MAR/MDR, counters and response registers.
  always_ff @(posedge Clk) begin
    if (!Clr) begin
      rw_q      <= 1'b0;
      sgn_q     <= 1'b0;
      size_q    <= SZ_BYTE;
      phase_q   <= 1'b0;
      wlo_q     <= '0;
      mar_out   <= '0;
      mdr_out   <= '0;
      setup_cnt <= '0;
      tmo_cnt   <= '0;
      rdata_q   <= '0;
      mis_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (req_valid) begin
          rw_q      <= req_rw;
          sgn_q     <= req_signed;
          size_q    <= req_size;
          phase_q   <= 1'b0;
          wlo_q     <= req_wdata[31:0];
          mar_out   <= req_addr;
          // Phase 0 of a doubleword stores the even register (upper half).
          mdr_out   <= (req_size == SZ_DOUBLE) ? req_wdata[63:32] : req_wdata[31:0];
          setup_cnt <= '0;
          tmo_cnt   <= '0;
          rdata_q   <= '0;
          mis_q     <= is_misaligned(req_size, req_addr[2:0]);
          tmo_q     <= 1'b0;
        end
        ST_SETUP:
          setup_cnt <= (setup_cnt == SETUP_LAST) ? '0 : setup_cnt + 1'b1;
        ST_ACCESS: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (!MFC && tmo_cnt == TMO_LAST) begin
            tmo_q   <= 1'b1;
            rdata_q <= '0;  // drop any phase-0 data on an aborted doubleword
          end
        end
        ST_LATCH: if (!rw_q) begin
          if (size_q == SZ_DOUBLE && !phase_q) rdata_q[63:32] <= aligned;
          else                                 rdata_q[31:0]  <= aligned;
        end
        ST_NEXT: begin
          mar_out   <= mar_out + 32'd4;
          mdr_out   <= wlo_q;
          phase_q   <= 1'b1;
          tmo_cnt   <= '0;
          setup_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with a small RAM responder model.
module tb_mem_access_sequencer;

  logic        Clk = 1'b0;
  logic        Clr = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rw = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        MFC;
  logic [31:0] ram_rdata;
  logic [31:0] mar_out, mdr_out;
  logic        RAM_enable;
  logic [5:0]  RAM_OpCode;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_misaligned, rsp_timeout;

  mem_access_sequencer dut (
    .Clk(Clk), .Clr(Clr), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .MFC(MFC), .ram_rdata(ram_rdata),
    .mar_out(mar_out), .mdr_out(mdr_out), .RAM_enable(RAM_enable),
    .RAM_OpCode(RAM_OpCode), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_misaligned(rsp_misaligned), .rsp_timeout(rsp_timeout)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RAM responder: MFC after mfc_delay enabled cycles (0 = never); hi_silent
  // withholds MFC for addresses with bit 2 set; addr_mode returns tagged data.
  int          mfc_delay = 0;
  bit          hi_silent = 0;
  bit          addr_mode = 0;
  logic [31:0] ram_val = '0;
  int          en_run = 0;

  always @(posedge Clk) en_run <= RAM_enable ? en_run + 1 : 0;

  always_comb begin
    MFC = RAM_enable && (mfc_delay != 0) && (en_run == mfc_delay - 1)
          && !(hi_silent && mar_out[2]);
    ram_rdata = addr_mode ? {16'hCAFE, mar_out[15:0]} : ram_val;
  end

  // Monitor, sampled on the falling edge.
  int          cyc = 0;
  int          en_cycles = 0;
  int          pulses = 0;
  int          rsp_cyc = 0;
  bit          prev_en = 0;
  logic [63:0] got_rdata;
  logic        got_mis, got_to;
  logic [31:0] mar_q[$];
  logic [31:0] mdr_q[$];
  logic [5:0]  op_q[$];

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (RAM_enable) begin
      en_cycles++;
      if (!prev_en) begin
        mar_q.push_back(mar_out);
        mdr_q.push_back(mdr_out);
        op_q.push_back(RAM_OpCode);
      end
    end
    prev_en = RAM_enable;
    if (rsp_valid) begin
      pulses++;
      rsp_cyc   = cyc;
      got_rdata = rsp_rdata;
      got_mis   = rsp_misaligned;
      got_to    = rsp_timeout;
    end
  end

  task automatic clear_mon();
    en_cycles = 0;
    pulses    = 0;
    got_rdata = 'x;
    got_mis   = 1'bx;
    got_to    = 1'bx;
    mar_q.delete();
    mdr_q.delete();
    op_q.delete();
  endtask

  // Issue one request, wait (bounded) for its response, return latency.
  task automatic run_req(input logic rw, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [63:0] wdata,
                         output int lat);
    int t0, n;
    @(posedge Clk); #1;
    clear_mon();
    req_rw = rw; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    t0 = cyc;
    @(posedge Clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (pulses == 0 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    repeat (3) @(negedge Clk);
    chk("rsp_pulses", pulses, 1);
    lat = rsp_cyc - t0;
  endtask

  int lat;

  initial begin
    // Reset
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_ready",  req_ready, 1);
    chk("rst_enable", RAM_enable, 0);
    chk("rst_valid",  rsp_valid, 0);
    chk("rst_mar",    mar_out, 0);
    chk("rst_mdr",    mdr_out, 0);
    chk("rst_opcode", RAM_OpCode, 0);
    chk("rst_rdata",  rsp_rdata, 0);
    chk("rst_flags",  {rsp_misaligned, rsp_timeout}, 0);
    Clr = 1'b1;

    // Word load, MFC on 2nd enabled cycle
    mfc_delay = 2; ram_val = 32'hDEADBEEF;
    run_req(0, 2'b10, 0, 32'h10, 64'h0, lat);
    chk("wl_rdata",  got_rdata, 64'h0000_0000_DEAD_BEEF);
    chk("wl_flags",  {got_mis, got_to}, 0);
    chk("wl_en_cyc", en_cycles, 2);
    chk("wl_lat",    lat, 5);
    chk("wl_mar",    mar_q[0], 32'h10);
    chk("wl_op",     op_q[0], 6'b000010);

    // Byte loads, signed and unsigned
    mfc_delay = 1; ram_val = 32'h1234_5680;
    run_req(0, 2'b00, 1, 32'h21, 64'h0, lat);
    chk("sb_rdata", got_rdata, 64'h0000_0000_FFFF_FF80);
    chk("sb_op",    op_q[0], 6'b000100);
    chk("sb_lat",   lat, 4);
    run_req(0, 2'b00, 0, 32'h21, 64'h0, lat);
    chk("ub_rdata", got_rdata, 64'h0000_0000_0000_0080);

    // Half loads, signed and unsigned
    ram_val = 32'h5555_8001;
    run_req(0, 2'b01, 1, 32'h22, 64'h0, lat);
    chk("sh_rdata", got_rdata, 64'h0000_0000_FFFF_8001);
    run_req(0, 2'b01, 0, 32'h22, 64'h0, lat);
    chk("uh_rdata", got_rdata, 64'h0000_0000_0000_8001);

    // Word store
    run_req(1, 2'b10, 0, 32'h40, 64'h0123_4567_AABB_CCDD, lat);
    chk("ws_mdr",   mdr_q[0], 32'hAABB_CCDD);
    chk("ws_op",    op_q[0], 6'b001010);
    chk("ws_rdata", got_rdata, 0);

    // Doubleword store split into two phases
    run_req(1, 2'b11, 0, 32'h08, 64'h1111_1111_2222_2222, lat);
    chk("ds_phases", op_q.size(), 2);
    if (op_q.size() == 2) begin
      chk("ds_mar0", mar_q[0], 32'h08);
      chk("ds_mdr0", mdr_q[0], 32'h1111_1111);
      chk("ds_mar1", mar_q[1], 32'h0C);
      chk("ds_mdr1", mdr_q[1], 32'h2222_2222);
      chk("ds_op0",  op_q[0], 6'b001010);
      chk("ds_op1",  op_q[1], 6'b001010);
    end
    chk("ds_rdata", got_rdata, 0);
    chk("ds_en_cyc", en_cycles, 2);

    // Doubleword load: even word to [63:32]
    addr_mode = 1; mfc_delay = 3;
    run_req(0, 2'b11, 0, 32'h18, 64'h0, lat);
    chk("dl_rdata", got_rdata, 64'hCAFE_0018_CAFE_001C);
    chk("dl_lat",   lat, 12);
    chk("dl_flags", {got_mis, got_to}, 0);

    // Misaligned requests: one-cycle response, no RAM access
    run_req(0, 2'b01, 0, 32'h03, 64'h0, lat);
    chk("mh_flags", {got_mis, got_to}, 2'b10);
    chk("mh_lat",   lat, 1);
    chk("mh_en",    en_cycles, 0);
    run_req(0, 2'b10, 0, 32'h02, 64'h0, lat);
    chk("mw_flags", {got_mis, got_to}, 2'b10);
    run_req(1, 2'b11, 0, 32'h04, 64'h0, lat);
    chk("md_flags", {got_mis, got_to}, 2'b10);
    chk("md_en",    en_cycles, 0);

    // Timeout on word load
    mfc_delay = 0; addr_mode = 0;
    run_req(0, 2'b10, 0, 32'h50, 64'h0, lat);
    chk("to_flags",  {got_mis, got_to}, 2'b01);
    chk("to_en_cyc", en_cycles, 16);
    chk("to_rdata",  got_rdata, 0);
    chk("to_lat",    lat, 18);
    chk("to_ready",  req_ready, 1);
    chk("to_enable", RAM_enable, 0);

    // Timeout in doubleword phase 1 discards phase-0 data
    mfc_delay = 1; hi_silent = 1; addr_mode = 1;
    run_req(0, 2'b11, 0, 32'h20, 64'h0, lat);
    chk("dt_flags",  {got_mis, got_to}, 2'b01);
    chk("dt_rdata",  got_rdata, 0);
    chk("dt_en_cyc", en_cycles, 17);

    // Reset during phase 1 ACCESS of a doubleword load
    @(posedge Clk); #1;
    clear_mon();
    req_rw = 0; req_size = 2'b11; req_signed = 0; req_addr = 32'h30; req_valid = 1'b1;
    @(posedge Clk); #1;
    req_valid = 1'b0;
    for (int n = 0; n < 50 && !(RAM_enable && mar_out[2]); n++) begin
      @(posedge Clk); #1;
    end
    chk("rm_reach_ph1", RAM_enable && mar_out[2], 1);
    Clr = 1'b0;
    @(posedge Clk); #1;
    chk("rm_enable", RAM_enable, 0);
    chk("rm_ready",  req_ready, 1);
    chk("rm_mar",    mar_out, 0);
    Clr = 1'b1;
    repeat (25) @(posedge Clk);
    #1;
    chk("rm_no_rsp", pulses, 0);

    // Normal word load after reset
    hi_silent = 0; addr_mode = 0; mfc_delay = 2; ram_val = 32'hCAFE_F00D;
    run_req(0, 2'b10, 0, 32'h60, 64'h0, lat);
    chk("pr_rdata", got_rdata, 64'h0000_0000_CAFE_F00D);
    chk("pr_flags", {got_mis, got_to}, 0);
    chk("pr_lat",   lat, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Multi-cycle memory access sequencer that sits between the control unit and the RAM port of the SPARC datapath.
- It accepts one load/store request at a time and owns the MAR/MDR values presented to RAM.
- It drives RAM_enable and RAM_OpCode, waits for MFC with a bounded timeout, and splits doubleword (LDD/STD) accesses into two word accesses.
- It returns sign/zero-extended load data and flags misalignment or timeout so the control unit can raise a trap.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in ACCESS waiting for MFC before abort.
- SETUP_CYCLES, 1: cycles MAR/MDR are held stable before RAM_enable asserts.

Ports:
- Clk  in  1  system clock, rising edge.
- Clr  in  1  synchronous, active-low reset.
- req_valid  in  1  request strobe; accepted when req_valid & req_ready.
- req_ready  out  1  high only in IDLE.
- req_rw  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 doubleword.
- req_signed  in  1  sign-extend load (byte/half only).
- req_addr  in  32  effective address (ALU_out).
- req_wdata  in  64  store data; word 0 = [63:32] (even register), word 1 = [31:0].
- MFC  in  1  memory function complete from RAM.
- ram_rdata  in  32  RAM_Out.
- mar_out  out  32  address to RAM.
- mdr_out  out  32  store data to RAM.
- RAM_enable  out  1  RAM access strobe.
- RAM_OpCode  out  6  {2'b00, rw, signed, size[1:0]}; for doubleword phases size field = 10.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  64  load result; [31:0] valid for non-double accesses, [63:32] = 0.
- rsp_misaligned  out  1  qualified by rsp_valid.
- rsp_timeout  out  1  qualified by rsp_valid.

Behaviour:
- Reset (Clr = 0 at a rising edge):
  - State = IDLE.
  - All outputs 0 except req_ready = 1.
  - Internal counters cleared.
  - Reset mid-access drops RAM_enable the next cycle and produces no response.
- States: IDLE, SETUP, ACCESS, LATCH, NEXT, DONE.
- IDLE, on accept, latch rw, size, signed, addr, and wdata.
- Alignment check at accept:
  - Misaligned when half has addr[0] ≠ 0, word has addr[1:0] ≠ 0, or double has addr[2:0] ≠ 0.
  - If misaligned, go to DONE directly with rsp_misaligned = 1. No RAM access occurs (RAM_enable never rises).
  - Otherwise go to SETUP.
- SETUP:
  - mar_out = address; mdr_out = write word for the current phase.
  - RAM_enable = 0.
  - Hold SETUP_CYCLES cycles, then go to ACCESS.
- ACCESS:
  - RAM_enable = 1; mar_out, mdr_out, and RAM_OpCode are held stable.
  - Timeout counter increments each cycle.
  - On MFC = 1, go to LATCH.
  - When the counter reaches TIMEOUT_CYCLES without MFC, go to DONE with rsp_timeout = 1 and RAM_enable = 0 next cycle.
  - If MFC and the timeout condition occur in the same cycle, MFC wins.
- LATCH:
  - RAM_enable = 0.
  - On a load, capture ram_rdata into the phase word:
    - byte: [7:0] extended by req_signed from bit 7.
    - half: [15:0] extended from bit 15.
    - word/double: unmodified.
  - If double and phase 0, go to NEXT; otherwise go to DONE.
- NEXT: address += 4 (32-bit wrap), phase = 1, timeout counter cleared, go to SETUP.
- DONE:
  - rsp_valid = 1 for exactly one cycle; rsp_rdata/flags valid this cycle and held until the next accept.
  - Return to IDLE.
- Stores return rsp_rdata = 0.
- A timeout during phase 1 reports the timeout; any data captured in phase 0 is discarded (rsp_rdata = 0).
- req_valid while not IDLE is ignored (req_ready = 0).
- Latency from accept to rsp_valid:
  - Single access: 1 + SETUP_CYCLES + (cycles to MFC, ≥ 1) + 1.
  - Misaligned: 1 cycle.

Decomposition:
- Shared package: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DOUBLE), state encodings, and the RAM_OpCode field layout.
- One sub-module, load_data_aligner: combinational byte/half/word extraction and sign/zero extension.
- The FSM, counters, and latches stay in mem_access_sequencer.

Test Plan:
- Word load, addr 0x0000_0010, RAM returns 0xDEADBEEF with MFC 2 cycles after enable -> one rsp_valid pulse, rsp_rdata = 0x0000_0000_DEADBEEF, flags 0, RAM_enable high exactly 2 cycles.
- Signed byte load, ram_rdata[7:0] = 0x80 -> rsp_rdata[31:0] = 0xFFFFFF80; same access unsigned -> 0x00000080.
- Doubleword store, addr 0x0000_0008, wdata 0x11111111_22222222 -> two ACCESS phases: mar_out = 0x08 with mdr_out = 0x11111111, then mar_out = 0x0C with mdr_out = 0x22222222; RAM_OpCode rw = 1, size = 10.
- Half load, addr 0x0000_0003 -> rsp_valid the cycle after accept with rsp_misaligned = 1, RAM_enable never asserted.
- Word load with MFC held 0 -> RAM_enable high for 16 cycles, then rsp_timeout = 1, RAM_enable = 0, return to IDLE with req_ready = 1.
- Clr = 0 asserted during ACCESS of an LDD phase 1 -> next cycle IDLE, RAM_enable = 0, rsp_valid never pulses; a new word request then completes normally.
